// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, beat types and response codes used by the register-file slave.
package axi_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Merge new_d into old byte-by-byte wherever the strobe is set.
  function automatic data_t apply_strb(data_t old, data_t new_d, strb_t strb);
    data_t res;
    res = old;
    for (int unsigned j = 0; j < STRB_W; j++) begin
      if (strb[j]) res[8*j +: 8] = new_d[8*j +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// Single-entry valid/ready holding register: accepts one beat while empty, keeps it until cleared.
module axi_lite_hold_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         clear_i,
  output logic         held_o,
  output logic [W-1:0] data_o
);

  logic         held_q, held_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (valid_i && !held_q) begin
      held_d = 1'b1;
      data_d = data_i;
    end else if (clear_i) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS 32-bit registers with byte strobes, read-only status slots
// fed from reg_in, and per-register write pulses towards the core.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned              NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]      RO_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0]   RESET_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  addr_t                     aw_addr;
  logic                      aw_held, w_held;
  logic [STRB_W+DATA_W-1:0]  w_bundle;
  data_t                     w_data;
  strb_t                     w_strb;
  logic                      write_fire;

  data_t                     regs_q [NUM_REGS];
  data_t                     regs_d [NUM_REGS];
  data_t                     reg_in_a [NUM_REGS];
  logic                      bvalid_q, bvalid_d;
  resp_t                     bresp_q, bresp_d;
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic                      rvalid_q, rvalid_d;
  data_t                     rdata_q, rdata_d;
  resp_t                     rresp_q, rresp_d;

  logic [IDXW-1:0]           wr_idx, rd_idx;
  logic                      wr_in_range, rd_in_range, wr_err, ar_fire;
  logic                      unused_addr_lsbs;

  axi_lite_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk_i   (aclk),
    .reset_i (reset),
    .valid_i (awvalid),
    .data_i  (awaddr),
    .ready_o (awready),
    .clear_i (write_fire),
    .held_o  (aw_held),
    .data_o  (aw_addr)
  );

  axi_lite_hold_reg #(.W(STRB_W + DATA_W)) u_w_hold (
    .clk_i   (aclk),
    .reset_i (reset),
    .valid_i (wvalid),
    .data_i  ({wstrb, wdata}),
    .ready_o (wready),
    .clear_i (write_fire),
    .held_o  (w_held),
    .data_o  (w_bundle)
  );

  assign w_data = w_bundle[DATA_W-1:0];
  assign w_strb = w_bundle[STRB_W+DATA_W-1:DATA_W];

  // Byte offset within a word is don't-care for decode.
  assign unused_addr_lsbs = ^{aw_addr[1:0], araddr[1:0]};

  assign write_fire  = aw_held && w_held && (!bvalid_q || bready);
  assign wr_idx      = aw_addr[2 +: IDXW];
  assign wr_in_range = (aw_addr >> (IDXW + 2)) == '0;
  assign wr_err      = !wr_in_range || RO_MASK[wr_idx];

  assign ar_fire     = arvalid && !rvalid_q;
  assign rd_idx      = araddr[2 +: IDXW];
  assign rd_in_range = (araddr >> (IDXW + 2)) == '0;

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign arready  = !rvalid_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_in_a[i] = reg_in[i*DATA_W +: DATA_W];
      reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
    end
  end

  // A B handshake and a new write can share an edge: clear first, then re-arm.
  always_comb begin
    regs_d     = regs_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (write_fire) begin
      bvalid_d = 1'b1;
      if (wr_err) begin
        bresp_d = SLVERR;
      end else begin
        bresp_d = OKAY;
        if (w_strb != '0) begin
          regs_d[wr_idx]     = apply_strb(regs_q[wr_idx], w_data, w_strb);
          wr_pulse_d[wr_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      if (!rd_in_range) begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end else begin
        rdata_d = RO_MASK[rd_idx] ? reg_in_a[rd_idx] : regs_q[rd_idx];
        rresp_d = OKAY;
      end
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      regs_q     <= regs_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
